wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Writeback stage for the Banff core; the write side of the Decode-stage register file.
- Accepts completed results from the ALU and the load/store unit (LSU) over valid/ready handshakes.
- Arbitrates round-robin between them and sign/zero-extends load data.
- Drives the register file's single registered write port, a same-cycle forwarding copy for Decode, and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register address width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  REG_ADDR_W  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  load result accepted this cycle.
- lsu_rd  in  REG_ADDR_W  load destination register.
- lsu_data  in  XLEN  raw aligned memory word.
- lsu_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- lsu_addr_lo  in  2  byte offset of the load address.
- rf_we  out  1  register file write enable.
- rf_waddr  out  REG_ADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- fwd_valid  out  1  forwarding copy of rf_we, for the Decode bypass.
- fwd_rd  out  REG_ADDR_W  forwarding copy of rf_waddr.
- fwd_data  out  XLEN  forwarding copy of rf_wdata.
- lsu_err  out  1  one-cycle pulse: illegal lsu_funct3 accepted.
- instret  out  64  count of retired results.

Behaviour:
- Reset (asynchronous assertion, synchronous release to clock): rf_we=0, rf_waddr=0, rf_wdata=0, all fwd_* = 0, lsu_err=0, instret=0, prio=ALU.
- Handshake:
  - A transfer occurs when valid && ready at a rising edge.
  - ready is combinational from the two valids and prio. Valid must not depend on ready.
  - Producers hold rd/data stable while valid && !ready.
- Arbitration (1-bit prio register):
  - Only one valid: that source gets ready=1.
  - Both valid: source named by prio gets ready; the other sees ready=0.
  - After any granted transfer, prio points to the non-granted source. A continuously valid source is therefore served at most every second cycle under contention.
  - Neither valid: both readys=1, which is harmless since no transfer occurs; prio is unchanged.
- Write stage, latency 1 cycle from transfer to rf_we:
  - On a transfer: rf_waddr=rd, rf_wdata=result, rf_we=(rd!=0).
  - No transfer: rf_we=0; rf_waddr and rf_wdata hold their values.
- Writes to x0: the handshake completes and instret increments, but rf_we stays 0.
- fwd_valid/fwd_rd/fwd_data are always identical to rf_we/rf_waddr/rf_wdata.
- Load extraction, applied to lsu_data before the write-stage register:
  - LB/LBU: byte lsu_addr_lo, sign- or zero-extended.
  - LH/LHU: halfword lsu_addr_lo[1], sign- or zero-extended; lsu_addr_lo[0] is ignored.
  - LW: whole word; lsu_addr_lo is ignored.
  - funct3 3, 6, 7: write data 0, the write is still performed if rd!=0, and lsu_err=1 for exactly the following cycle.
- instret increments by 1 per transfer (at most one per cycle) and wraps from 2^64-1 to 0.
- Reset asserted mid-stream: the in-flight write is discarded (rf_we=0 immediately); prio returns to ALU.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF for one cycle -> alu_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, fwd_* equal; instret=1.
- Load rd=3, funct3=0 (LB), addr_lo=2, lsu_data=0x12_80_34_56 -> rf_wdata=0xFFFFFF80. Repeat with LBU -> 0x00000080; LH with addr_lo=2 -> 0x00001280; LHU with lsu_data=0x8001_0000 and addr_lo=2 -> 0x00008001.
- alu_valid and lsu_valid both held high for 4 cycles after reset -> grants ALU, LSU, ALU, LSU; rf_we high on 4 consecutive cycles; instret=4.
- alu_valid with rd=0, data=0x1 -> alu_ready=1, rf_we stays 0, instret increments.
- Load with funct3=7, rd=9 -> rf_we=1, rf_waddr=9, rf_wdata=0, lsu_err high for exactly one cycle.
- reset deasserted to 0 (asserted) while a transfer's rf_we is pending -> rf_we, instret and all outputs read 0 asynchronously; after release the first grant under contention goes to the ALU.

Source files
------------

// File: rtl/wb_unit.sv
// Writeback stage: round-robin ALU/LSU result arbitration, load extraction,
// registered register-file write port with a forwarding copy and instret counter.
module wb_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic [2:0]            lsu_funct3,
  input  logic [1:0]            lsu_addr_lo,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  lsu_err,
  output logic [63:0]           instret
);

  typedef enum logic {PRIO_ALU = 1'b0, PRIO_LSU = 1'b1} prio_t;

  prio_t                  prio_reg, prio_next;
  logic                   rf_we_reg, rf_we_next;
  logic [REG_ADDR_W-1:0]  rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0]        rf_wdata_reg, rf_wdata_next;
  logic                   lsu_err_reg, lsu_err_next;
  logic [63:0]            instret_reg, instret_next;

  logic                   alu_fire, lsu_fire;
  logic [7:0]             lsu_bytes [4];
  logic [7:0]             lsu_byte;
  logic [15:0]            lsu_half;
  logic [XLEN-1:0]        load_data;
  logic                   load_illegal;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lsu_bytes[gi] = lsu_data[8*gi +: 8];
    end
  endgenerate

  // The loser is only stalled when both sources compete.
  assign alu_ready = !(alu_valid && lsu_valid) || (prio_reg == PRIO_ALU);
  assign lsu_ready = !(alu_valid && lsu_valid) || (prio_reg == PRIO_LSU);
  assign alu_fire  = alu_valid && alu_ready;
  assign lsu_fire  = lsu_valid && lsu_ready;

  always_comb begin
    lsu_byte     = lsu_bytes[lsu_addr_lo];
    lsu_half     = lsu_addr_lo[1] ? lsu_data[31:16] : lsu_data[15:0];
    load_data    = '0;
    load_illegal = 1'b0;
    case (lsu_funct3)
      3'd0:    load_data = {{(XLEN-8){lsu_byte[7]}}, lsu_byte};
      3'd1:    load_data = {{(XLEN-16){lsu_half[15]}}, lsu_half};
      3'd2:    load_data = lsu_data;
      3'd4:    load_data = {{(XLEN-8){1'b0}}, lsu_byte};
      3'd5:    load_data = {{(XLEN-16){1'b0}}, lsu_half};
      default: load_illegal = 1'b1;
    endcase
  end

  always_comb begin
    prio_next     = prio_reg;
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    lsu_err_next  = 1'b0;
    instret_next  = instret_reg;
    if (alu_fire) begin
      prio_next     = PRIO_LSU;
      rf_we_next    = (alu_rd != '0);
      rf_waddr_next = alu_rd;
      rf_wdata_next = alu_data;
      instret_next  = instret_reg + 64'd1;
    end else if (lsu_fire) begin
      prio_next     = PRIO_ALU;
      rf_we_next    = (lsu_rd != '0);
      rf_waddr_next = lsu_rd;
      rf_wdata_next = load_data;
      lsu_err_next  = load_illegal;
      instret_next  = instret_reg + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio_reg     <= PRIO_ALU;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      lsu_err_reg  <= 1'b0;
      instret_reg  <= '0;
    end else begin
      prio_reg     <= prio_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      lsu_err_reg  <= lsu_err_next;
      instret_reg  <= instret_next;
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign fwd_valid = rf_we_reg;
  assign fwd_rd    = rf_waddr_reg;
  assign fwd_data  = rf_wdata_reg;
  assign lsu_err   = lsu_err_reg;
  assign instret   = instret_reg;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: ALU writes, load extraction, contention,
// x0 writes, illegal loads and asynchronous reset mid-stream.
module tb_wb_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [1:0]  lsu_addr_lo = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        lsu_err;
  logic [63:0] instret;

  int err_cnt = 0;
  int chk_cnt = 0;
  longint unsigned exp_instret = 0;

  always #5 clock = ~clock;

  wb_unit dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .lsu_err(lsu_err), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd);
    chk({tag, "_we"},   64'(rf_we), 64'(we));
    chk({tag, "_fwdv"}, 64'(fwd_valid), 64'(we));
    if (we) begin
      chk({tag, "_wa"},   64'(rf_waddr), 64'(wa));
      chk({tag, "_wd"},   64'(rf_wdata), 64'(wd));
      chk({tag, "_fwdr"}, 64'(fwd_rd), 64'(wa));
      chk({tag, "_fwdd"}, 64'(fwd_data), 64'(wd));
    end
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] d, input logic [31:0] exp);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_funct3 = f3; lsu_addr_lo = lo; lsu_data = d;
    #1;
    chk({tag, "_rdy"}, 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    exp_instret++;
    chk_write(tag, 1'b1, rd, exp);
    chk({tag, "_err"}, 64'(lsu_err), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_wa", 64'(rf_waddr), 64'd0);
    chk("rst_wd", 64'(rf_wdata), 64'd0);
    chk("rst_fwd", {27'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
    chk("rst_err", 64'(lsu_err), 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // single ALU result
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_rdy", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    exp_instret++;
    chk_write("alu", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu_instret", instret, 64'd1);
    tick();
    chk("idle_we", 64'(rf_we), 64'd0);
    chk("idle_hold_wa", 64'(rf_waddr), 64'd5);
    chk("idle_hold_wd", 64'(rf_wdata), 64'hDEADBEEF);

    // load extraction
    do_load("lb",  5'd3, 3'd0, 2'd2, 32'h12803456, 32'hFFFFFF80);
    do_load("lbu", 5'd3, 3'd4, 2'd2, 32'h12803456, 32'h00000080);
    do_load("lh",  5'd3, 3'd1, 2'd2, 32'h12803456, 32'h00001280);
    do_load("lhu", 5'd3, 3'd5, 2'd2, 32'h80010000, 32'h00008001);
    do_load("lh0", 5'd4, 3'd1, 2'd1, 32'h0000F00D, 32'hFFFFF00D);
    do_load("lb3", 5'd4, 3'd0, 2'd3, 32'h7F000000, 32'h0000007F);
    do_load("lw",  5'd6, 3'd2, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("load_instret", instret, 64'(exp_instret));

    // x0 write: handshake and count, no write enable
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    #1;
    chk("x0_rdy", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    exp_instret++;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_fwdv", 64'(fwd_valid), 64'd0);
    chk("x0_instret", instret, 64'(exp_instret));

    // illegal load type
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'd7; lsu_addr_lo = 2'd0; lsu_data = 32'h55AA55AA;
    #1;
    chk("ill_rdy", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    exp_instret++;
    chk_write("ill", 1'b1, 5'd9, 32'h0);
    chk("ill_err", 64'(lsu_err), 64'd1);
    tick();
    chk("ill_err_clr", 64'(lsu_err), 64'd0);
    chk("ill_instret", instret, 64'(exp_instret));

    // fresh reset, then contention for 4 cycles
    reset = 1'b0;
    #1;
    chk("rst2_instret", instret, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    exp_instret = 0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0A0A0A0;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_funct3 = 3'd2; lsu_data = 32'hB0B0B0B0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_ardy", i), 64'(alu_ready), 64'((i % 2) == 0));
      chk($sformatf("cont%0d_lrdy", i), 64'(lsu_ready), 64'((i % 2) == 1));
      tick();
      exp_instret++;
      if ((i % 2) == 0) chk_write($sformatf("cont%0d", i), 1'b1, 5'd1, 32'hA0A0A0A0);
      else              chk_write($sformatf("cont%0d", i), 1'b1, 5'd2, 32'hB0B0B0B0);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("cont_instret", instret, 64'd4);

    // ALU transfer leaves prio at LSU and a write pending; reset wipes both
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h12345678;
    tick();
    alu_valid = 1'b0;
    chk("pend_we", 64'(rf_we), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_we", 64'(rf_we), 64'd0);
    chk("async_wa", 64'(rf_waddr), 64'd0);
    chk("async_wd", 64'(rf_wdata), 64'd0);
    chk("async_fwd", {27'd0, fwd_valid, fwd_rd, fwd_data}, 64'd0);
    chk("async_instret", instret, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    chk("post_rst_ardy", 64'(alu_ready), 64'd1);
    chk("post_rst_lrdy", 64'(lsu_ready), 64'd0);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk_write("post_rst", 1'b1, 5'd7, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
